// File: rtl/otter_rf_write_arbiter.sv
// Two-requester register-file write arbiter with an optional post-reset clear sweep.
// Latency: a write accepted on edge N is presented on RF_* during cycle N+1; the clear sweep takes 31 cycles.
// Backpressure: REQn_READY is combinational. It is withheld during reset, during the sweep and from the contention loser.
//
// Ports:
//   CLK, RST                          clock, asynchronous active-high reset
//   REQn_VALID/ADDR/DATA -> READY     per-requester write request (n = 0, 1); transfer when VALID & READY
//   RF_WA, RF_WD, RF_EN               registered register-file write port
//   BUSY                              registered, high while the clear sweep is still running
module otter_rf_write_arbiter #(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ0_VALID,
    input  logic [4:0]  REQ0_ADDR,
    input  logic [31:0] REQ0_DATA,
    output logic        REQ0_READY,
    input  logic        REQ1_VALID,
    input  logic [4:0]  REQ1_ADDR,
    input  logic [31:0] REQ1_DATA,
    output logic        REQ1_READY,
    output logic [4:0]  RF_WA,
    output logic [31:0] RF_WD,
    output logic        RF_EN,
    output logic        BUSY
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;
    localparam logic [4:0] LAST_CLR_ADDR = 5'd31;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    // 1 means requester 1 received the most recent grant.
    logic        last_q, last_d;
    logic        rf_en_q, rf_en_d;
    logic [4:0]  rf_wa_q, rf_wa_d;
    logic [31:0] rf_wd_q, rf_wd_d;
    logic        busy_q, busy_d;

    logic        arb_ok;
    logic        gnt0;
    logic        gnt1;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;

    // Grant logic. A requester that is alone wins. Under contention, the requester
    // that did not win last time is granted. RST gates the grants so the READYs
    // drop at the same moment the registers clear.
    always_comb begin
        arb_ok = (state_q == ST_ARB) && !RST;
        gnt0   = arb_ok && REQ0_VALID && (!REQ1_VALID || last_q);
        gnt1   = arb_ok && REQ1_VALID && (!REQ0_VALID || !last_q);
    end

    assign REQ0_READY = gnt0;
    assign REQ1_READY = gnt1;

    always_comb begin
        sel_addr = gnt1 ? REQ1_ADDR : REQ0_ADDR;
        sel_data = gnt1 ? REQ1_DATA : REQ0_DATA;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        rf_en_d = 1'b0;
        rf_wa_d = rf_wa_q;
        rf_wd_d = rf_wd_q;
        busy_d  = busy_q;

        case (state_q)
            ST_CLEAR: begin
                rf_en_d = 1'b1;
                rf_wa_d = cnt_q;
                rf_wd_d = 32'd0;
                if (cnt_q == LAST_CLR_ADDR) begin
                    // BUSY falls together with the x31 write. The counter is parked
                    // back at 1 so that it never reaches address 0.
                    state_d = ST_ARB;
                    busy_d  = 1'b0;
                    cnt_d   = 5'd1;
                end else begin
                    busy_d  = 1'b1;
                    cnt_d   = cnt_q + 5'd1;
                end
            end
            default: begin
                busy_d = 1'b0;
                if (gnt0 || gnt1) begin
                    last_d = gnt1;
                    // x0 is hardwired. The transfer is still accepted and still
                    // moves the pointer, but it does not produce a write.
                    if (sel_addr != 5'd0) begin
                        rf_en_d = 1'b1;
                        rf_wa_d = sel_addr;
                        rf_wd_d = sel_data;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RESET_STATE;
            cnt_q   <= 5'd1;
            last_q  <= 1'b1;
            rf_en_q <= 1'b0;
            rf_wa_q <= 5'd0;
            rf_wd_q <= 32'd0;
            busy_q  <= CLEAR_ON_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            rf_en_q <= rf_en_d;
            rf_wa_q <= rf_wa_d;
            rf_wd_q <= rf_wd_d;
            busy_q  <= busy_d;
        end
    end

    assign RF_EN = rf_en_q;
    assign RF_WA = rf_wa_q;
    assign RF_WD = rf_wd_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_otter_rf_write_arbiter.sv
// Randomized bench for otter_rf_write_arbiter, with and without the clear sweep, against a cycle-level reference.
// Latency: the reference advances once per rising edge and is compared on the falling edge.
// Backpressure: the expected READYs are derived from the reference's own grant rule.
module tb_otter_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;

    logic        r0_c, r1_c, en_c, busy_c;
    logic [4:0]  wa_c;
    logic [31:0] wd_c;
    logic        r0_n, r1_n, en_n, busy_n;
    logic [4:0]  wa_n;
    logic [31:0] wd_n;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    otter_rf_write_arbiter #(.CLEAR_ON_RESET(1'b1)) dut_clr (
        .CLK(clk), .RST(rst),
        .REQ0_VALID(v0), .REQ0_ADDR(a0), .REQ0_DATA(d0), .REQ0_READY(r0_c),
        .REQ1_VALID(v1), .REQ1_ADDR(a1), .REQ1_DATA(d1), .REQ1_READY(r1_c),
        .RF_WA(wa_c), .RF_WD(wd_c), .RF_EN(en_c), .BUSY(busy_c)
    );

    otter_rf_write_arbiter #(.CLEAR_ON_RESET(1'b0)) dut_nclr (
        .CLK(clk), .RST(rst),
        .REQ0_VALID(v0), .REQ0_ADDR(a0), .REQ0_DATA(d0), .REQ0_READY(r0_n),
        .REQ1_VALID(v1), .REQ1_ADDR(a1), .REQ1_DATA(d1), .REQ1_READY(r1_n),
        .RF_WA(wa_n), .RF_WD(wd_n), .RF_EN(en_n), .BUSY(busy_n)
    );

    // Reference state. Index 0 is the instance that sweeps, index 1 is the one that does not.
    // m_clr holds the next address to clear, or 0 when no sweep is running.
    int          m_clr  [2];
    int          m_last [2];
    logic        m_en   [2];
    logic [4:0]  m_wa   [2];
    logic [31:0] m_wd   [2];
    logic        m_busy [2];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h, want %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_en[k]   = 1'b0;
            m_wa[k]   = 5'd0;
            m_wd[k]   = 32'd0;
            m_last[k] = 1;
            m_clr[k]  = (k == 0) ? 1 : 0;
            m_busy[k] = (k == 0);
        end
    endtask

    // Returns the requester that should be granted this cycle, or -1 for none.
    function automatic int exp_grant(input int k);
        if (rst || m_clr[k] != 0) return -1;
        if (v0 && v1) return (m_last[k] == 1) ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic model_step();
        int g;
        if (rst) return;
        for (int k = 0; k < 2; k++) begin
            g = exp_grant(k);
            if (m_clr[k] != 0) begin
                m_en[k]   = 1'b1;
                m_wa[k]   = 5'(m_clr[k]);
                m_wd[k]   = 32'd0;
                m_busy[k] = (m_clr[k] != 31);
                m_clr[k]  = (m_clr[k] == 31) ? 0 : m_clr[k] + 1;
            end else begin
                m_busy[k] = 1'b0;
                m_en[k]   = 1'b0;
                if (g >= 0) begin
                    m_last[k] = g;
                    if (((g == 1) ? a1 : a0) != 5'd0) begin
                        m_en[k] = 1'b1;
                        m_wa[k] = (g == 1) ? a1 : a0;
                        m_wd[k] = (g == 1) ? d1 : d0;
                    end
                end
            end
        end
    endtask

    task automatic check_inst(input int k, input logic r0, input logic r1, input logic en,
                              input logic [4:0] wa, input logic [31:0] wd, input logic busy);
        string p;
        int g;
        p = (k == 0) ? "clr" : "nclr";
        g = exp_grant(k);
        check_val({p, ".ready0"}, 32'(r0), 32'(g == 0));
        check_val({p, ".ready1"}, 32'(r1), 32'(g == 1));
        check_val({p, ".onehot"}, 32'(r0 & r1), 32'd0);
        check_val({p, ".rf_en"}, 32'(en), 32'(m_en[k]));
        check_val({p, ".rf_wa"}, 32'(wa), 32'(m_wa[k]));
        check_val({p, ".rf_wd"}, wd, m_wd[k]);
        check_val({p, ".busy"}, 32'(busy), 32'(m_busy[k]));
    endtask

    // One clock: compare mid-cycle, then advance the reference on the edge.
    // The next inputs are driven 1 time unit after the edge.
    task automatic cycle();
        @(negedge clk);
        check_inst(0, r0_c, r1_c, en_c, wa_c, wd_c, busy_c);
        check_inst(1, r0_n, r1_n, en_n, wa_n, wd_n, busy_n);
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic set_rst(input logic b);
        rst = b;
        if (b) model_reset();
    endtask

    task automatic drive(input logic iv0, input logic [4:0] ia0, input logic [31:0] id0,
                         input logic iv1, input logic [4:0] ia1, input logic [31:0] id1);
        v0 = iv0; a0 = ia0; d0 = id0;
        v1 = iv1; a1 = ia1; d1 = id1;
    endtask

    task automatic drive_random();
        drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31)), $urandom(),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31)), $urandom());
    endtask

    initial begin
        set_rst(1'b1);
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd8, 32'h12345678);
        repeat (3) cycle();
        set_rst(1'b0);

        // Sweep with both requesters held valid, then alternating grants for x5/x8.
        repeat (36) cycle();

        // Lone requester 1 writing x0, followed by contention that requester 0 must win.
        drive(1'b0, 5'd5, 32'h1, 1'b1, 5'd0, 32'hFFFFFFFF);
        cycle();
        drive(1'b1, 5'd5, 32'h2, 1'b1, 5'd8, 32'h3);
        repeat (2) cycle();

        // Both requesters target x10.
        drive(1'b1, 5'd10, 32'hA, 1'b1, 5'd10, 32'hB);
        repeat (3) cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        repeat (2) cycle();

        for (int i = 0; i < 300; i++) begin
            drive_random();
            cycle();
        end

        // Reset during the sweep (12 clear cycles in), then a full restart.
        set_rst(1'b1);
        repeat (2) cycle();
        set_rst(1'b0);
        repeat (12) begin
            drive_random();
            cycle();
        end
        set_rst(1'b1);
        repeat (2) cycle();
        set_rst(1'b0);
        for (int i = 0; i < 40; i++) begin
            drive_random();
            cycle();
        end

        // Reset arrives in the cycle right after a transfer; the captured write must vanish.
        drive(1'b1, 5'd7, 32'hCAFEF00D, 1'b0, 5'd0, 32'h0);
        cycle();
        set_rst(1'b1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        repeat (2) cycle();
        set_rst(1'b0);

        for (int i = 0; i < 200; i++) begin
            drive_random();
            if ($urandom_range(0, 99) == 0) set_rst(1'b1);
            else if (rst) set_rst(1'b0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/otter_rf_write_arbiter.md
OTTER_RF_WRITE_ARBITER -- requirements
Module: otter_rf_write_arbiter

Interface
REQ-001 Parameter CLEAR_ON_RESET, default 1: when 1, a post-reset sweep zeroes registers x1..x31.
REQ-002 CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 RST  input  1  reset; asynchronous, active-high.
REQ-004 REQ0_VALID  input  1  requester 0 has a write pending.
REQ-005 REQ0_ADDR  input  5  requester 0 destination register.
REQ-006 REQ0_DATA  input  32  requester 0 write data.
REQ-007 REQ0_READY  output  1  requester 0 write accepted this cycle.
REQ-008 REQ1_VALID, REQ1_ADDR, REQ1_DATA, REQ1_READY  same widths/directions/meanings as REQ-004..007, for requester 1.
REQ-009 RF_WA  output  5  register-file write address.
REQ-010 RF_WD  output  32  register-file write data.
REQ-011 RF_EN  output  1  register-file write enable.
REQ-012 BUSY  output  1  clear sweep in progress.

Function
REQ-013 The block SHALL implement states CLEAR and ARB only.
REQ-014 RF_WA, RF_WD, RF_EN, BUSY SHALL be registered; REQn_READY SHALL be combinational from state, VALIDs and the last-grant pointer.
REQ-015 CLEAR: a 5-bit counter SHALL start at 1 and increment each cycle; each cycle drives RF_EN=1, RF_WA=counter, RF_WD=0 on the following cycle.
REQ-016 CLEAR SHALL last exactly 31 cycles (addresses 1..31), then enter ARB; the counter SHALL never wrap to 0 and address 0 SHALL never be written.
REQ-017 In CLEAR, both READYs SHALL be 0 and BUSY SHALL be 1; BUSY SHALL drop in the same cycle the last clear write (RF_WA=31) is presented.
REQ-018 With CLEAR_ON_RESET=0, the block SHALL enter ARB directly after reset and BUSY SHALL stay 0.
REQ-019 ARB handshake: a transfer occurs on a rising edge where REQn_VALID and REQn_READY are both 1; READY SHALL never be 1 while the matching VALID is 0.
REQ-020 At most one READY SHALL be 1 in any cycle.
REQ-021 Only one requester valid -> that requester SHALL get READY in the same cycle.
REQ-022 Both valid -> grant SHALL go to the requester not granted last; the last-grant pointer SHALL update only on a transfer.
REQ-023 After reset the last-grant pointer SHALL indicate requester 1, so requester 0 wins the first contention.
REQ-024 A transfer in cycle N SHALL produce RF_EN=1 with the captured address/data during cycle N+1 (one-cycle latency); RF_EN SHALL be 0 in any ARB cycle that follows a cycle with no transfer.
REQ-025 A transfer with ADDR=0 SHALL be accepted (READY=1) but produce RF_EN=0 in cycle N+1, and SHALL still update the last-grant pointer.
REQ-026 Back-to-back transfers SHALL be sustained: one write per cycle, no bubble.
REQ-027 Both requesters targeting the same register SHALL be written in grant order; the later grant's data persists.
REQ-028 When RF_EN=0, RF_WA and RF_WD SHALL hold their previous values.

Reset
REQ-029 RST asserted SHALL immediately force RF_EN=0, RF_WA=0, RF_WD=0, counter=1, last-grant=1, and BUSY=CLEAR_ON_RESET, with state=CLEAR if CLEAR_ON_RESET=1, else ARB.
REQ-030 While RST is high, both READYs SHALL be 0.
REQ-031 RST asserted mid-CLEAR or mid-ARB SHALL abort the operation; a pending captured write SHALL be discarded (no RF_EN after reset) and the sweep SHALL restart from address 1.

Verification
REQ-032 Release reset, both VALIDs held 1 -> 31 cycles of RF_EN=1 with RF_WA=1..31 and RF_WD=0, READYs 0, BUSY 1; ARB follows with BUSY=0.
REQ-033 In ARB, REQ0 (addr 5, 0xDEADBEEF) and REQ1 (addr 8, 0x12345678) held valid 4 cycles -> grants 0,1,0,1; RF_EN writes x5,x8,x5,x8 one cycle after each grant.
REQ-034 REQ1 alone valid, addr 0, data 0xFFFFFFFF -> REQ1_READY=1, next cycle RF_EN=0; next contention grants REQ0.
REQ-035 Both target addr 10, data 0xA and 0xB -> writes x10=0xA then x10=0xB on consecutive cycles.
REQ-036 Assert RST at clear cycle 12, release -> sweep restarts at RF_WA=1 and runs 31 cycles; RST asserted the cycle after a transfer -> no RF_EN pulse for that transfer.
